// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
// lif_neuron : leaky integrate-and-fire neuron with refractory hold and
//              per-window spike counting.                        Rev 1.0
// ============================================================================
module lif_neuron #(
   parameter int MEM_W      = 12,
   parameter int THRESH     = 256,
   parameter int V_RESET    = 0,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 2,
   parameter int NUM_STEPS  = 16,
   parameter int CNT_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    sum_valid,
   input  logic [7:0]              sum,
   output logic                    spike,
   output logic                    step_valid,
   output logic signed [MEM_W-1:0] v_mem,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        spike_count
);

   localparam int STEP_W = $clog2(NUM_STEPS + 1);
   localparam int REF_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

   localparam logic signed [MEM_W:0]   C_THRESH  = (MEM_W + 1)'(THRESH);
   localparam logic signed [MEM_W-1:0] C_V_RESET = MEM_W'(V_RESET);
   localparam logic signed [MEM_W-1:0] C_V_MAX   = {1'b0, {(MEM_W-1){1'b1}}};
   localparam logic signed [MEM_W-1:0] C_V_MIN   = {1'b1, {(MEM_W-1){1'b0}}};
   localparam logic [STEP_W-1:0]       C_LAST    = STEP_W'(NUM_STEPS - 1);
   localparam logic [REF_W-1:0]        C_REFRAC  = REF_W'(REFRAC);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_INTEGRATE = 2'd1,
      S_REFRACT   = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic signed [MEM_W-1:0]   v_mem_q, v_mem_d;
   logic                      spike_q, spike_d;
   logic                      step_valid_q, step_valid_d;
   logic                      done_q, done_d;
   logic [CNT_W-1:0]          spike_count_q, spike_count_d;
   logic [STEP_W-1:0]         step_ctr_q, step_ctr_d;
   logic [REF_W-1:0]          refrac_ctr_q, refrac_ctr_d;

   logic signed [MEM_W-1:0]   v_leak;
   logic signed [MEM_W:0]     v_sum;
   logic signed [MEM_W-1:0]   v_sat;

   // One guard bit catches overflow of leak + sum before clamping.
   always_comb begin
      v_leak = v_mem_q;
      if (LEAK_SHIFT != 0) begin
         v_leak = v_mem_q - (v_mem_q >>> LEAK_SHIFT);
      end
      v_sum = {v_leak[MEM_W-1], v_leak} + {{(MEM_W-7){sum[7]}}, sum};
      v_sat = v_sum[MEM_W-1:0];
      if (v_sum[MEM_W] != v_sum[MEM_W-1]) begin
         v_sat = v_sum[MEM_W] ? C_V_MIN : C_V_MAX;
      end
   end

   always_comb begin
      state_d       = state_q;
      v_mem_d       = v_mem_q;
      spike_d       = 1'b0;
      step_valid_d  = 1'b0;
      done_d        = 1'b0;
      spike_count_d = spike_count_q;
      step_ctr_d    = step_ctr_q;
      refrac_ctr_d  = refrac_ctr_q;

      if (start) begin
         state_d       = S_INTEGRATE;
         v_mem_d       = C_V_RESET;
         spike_count_d = '0;
         step_ctr_d    = '0;
         refrac_ctr_d  = '0;
      end else if (sum_valid && (state_q != S_IDLE)) begin
         step_valid_d = 1'b1;
         step_ctr_d   = step_ctr_q + 1'b1;
         if (state_q == S_INTEGRATE) begin
            if (v_sat >= C_THRESH) begin
               spike_d = 1'b1;
               v_mem_d = C_V_RESET;
               if (spike_count_q != {CNT_W{1'b1}}) begin
                  spike_count_d = spike_count_q + 1'b1;
               end
               if (REFRAC > 0) begin
                  state_d      = S_REFRACT;
                  refrac_ctr_d = C_REFRAC;
               end
            end else begin
               v_mem_d = v_sat;
            end
         end else begin
            v_mem_d      = C_V_RESET;
            refrac_ctr_d = refrac_ctr_q - 1'b1;
            if (refrac_ctr_q <= REF_W'(1)) begin
               state_d = S_INTEGRATE;
            end
         end
         // The window closes on its final step regardless of refractory state.
         if (step_ctr_q == C_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         v_mem_q       <= C_V_RESET;
         spike_q       <= 1'b0;
         step_valid_q  <= 1'b0;
         done_q        <= 1'b0;
         spike_count_q <= '0;
         step_ctr_q    <= '0;
         refrac_ctr_q  <= '0;
      end else begin
         state_q       <= state_d;
         v_mem_q       <= v_mem_d;
         spike_q       <= spike_d;
         step_valid_q  <= step_valid_d;
         done_q        <= done_d;
         spike_count_q <= spike_count_d;
         step_ctr_q    <= step_ctr_d;
         refrac_ctr_q  <= refrac_ctr_d;
      end
   end

   assign spike       = spike_q;
   assign step_valid  = step_valid_q;
   assign v_mem       = v_mem_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign spike_count = spike_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// ============================================================================
// tb_lif_neuron : directed self-checking bench for lif_neuron.       Rev 1.0
// ============================================================================
module tb_lif_neuron;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start, sum_valid;
   logic [7:0]         sum;
   logic               spike, step_valid, busy, done;
   logic signed [11:0] v_mem;
   logic [7:0]         spike_count;

   logic               b_start, b_sum_valid;
   logic [7:0]         b_sum;
   logic               b_spike, b_step_valid, b_busy, b_done;
   logic signed [11:0] b_v_mem;
   logic [7:0]         b_spike_count;

   int n_cmp = 0;
   int n_err = 0;

   // Expected per-step results for 16 steps of sum=0x7F with default parameters.
   int exp_v[16]   = '{127, 239, 0, 0, 0, 127, 239, 0, 0, 0, 127, 239, 0, 0, 0, 127};
   int exp_spk[16] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
   int exp_cnt[16] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3, 3};

   always #5 clk = ~clk;

   lif_neuron dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sum_valid(sum_valid), .sum(sum),
      .spike(spike), .step_valid(step_valid), .v_mem(v_mem), .busy(busy),
      .done(done), .spike_count(spike_count)
   );

   lif_neuron #(.LEAK_SHIFT(0), .NUM_STEPS(20)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .sum_valid(b_sum_valid), .sum(b_sum),
      .spike(b_spike), .step_valid(b_step_valid), .v_mem(b_v_mem), .busy(b_busy),
      .done(b_done), .spike_count(b_spike_count)
   );

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drive_step(input logic [7:0] s);
      sum = s; sum_valid = 1'b1;
      @(posedge clk); #1;
      sum_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (v_mem !== 12'sd0) begin n_err++; $display("FAIL reset_v_mem: got %0d want 0", v_mem); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (spike_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", spike_count); end
      n_cmp++; if ({spike, step_valid, done} !== 3'b000) begin
         n_err++; $display("FAIL reset_pulses: got %b want 000", {spike, step_valid, done});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_first_spike();
      pulse_start();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b want 1", busy); end
      drive_step(8'h7F);
      n_cmp++; if (v_mem !== 12'sd127 || spike !== 1'b0 || step_valid !== 1'b1) begin
         n_err++; $display("FAIL t1_step1: got v=%0d spk=%b sv=%b want v=127 spk=0 sv=1", v_mem, spike, step_valid);
      end
      drive_step(8'h7F);
      n_cmp++; if (v_mem !== 12'sd239 || spike !== 1'b0) begin
         n_err++; $display("FAIL t1_step2: got v=%0d spk=%b want v=239 spk=0", v_mem, spike);
      end
      drive_step(8'h7F);
      n_cmp++; if (v_mem !== 12'sd0 || spike !== 1'b1 || spike_count !== 8'd1) begin
         n_err++; $display("FAIL t1_step3: got v=%0d spk=%b cnt=%0d want v=0 spk=1 cnt=1", v_mem, spike, spike_count);
      end
   endtask

   task automatic test_full_window();
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         drive_step(8'h7F);
         n_cmp++;
         if (v_mem !== 12'(exp_v[i]) || spike !== exp_spk[i][0] || spike_count !== 8'(exp_cnt[i])
             || step_valid !== 1'b1 || done !== (i == 15) || busy !== (i != 15)) begin
            n_err++;
            $display("FAIL t2_step%0d: got v=%0d spk=%b cnt=%0d sv=%b done=%b busy=%b want v=%0d spk=%0d cnt=%0d sv=1 done=%0d busy=%0d",
                     i + 1, v_mem, spike, spike_count, step_valid, done, busy,
                     exp_v[i], exp_spk[i], exp_cnt[i], (i == 15), (i != 15));
         end
      end
      drive_step(8'h7F);
      n_cmp++; if (v_mem !== 12'sd127 || spike_count !== 8'd3 || done !== 1'b0 || step_valid !== 1'b0) begin
         n_err++; $display("FAIL t2_hold: got v=%0d cnt=%0d done=%b sv=%b want v=127 cnt=3 done=0 sv=0",
                           v_mem, spike_count, done, step_valid);
      end
   endtask

   task automatic test_saturation();
      logic any_spike;
      any_spike = 1'b0;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         b_sum = 8'h80; b_sum_valid = 1'b1;
         @(posedge clk); #1;
         b_sum_valid = 1'b0;
         any_spike = any_spike | b_spike;
         if (i == 1) begin
            n_cmp++; if (b_v_mem !== -12'sd128) begin n_err++; $display("FAIL t3_step1: got %0d want -128", b_v_mem); end
         end
         if (i == 15) begin
            n_cmp++; if (b_v_mem !== -12'sd1920) begin n_err++; $display("FAIL t3_step15: got %0d want -1920", b_v_mem); end
         end
         if (i == 16) begin
            n_cmp++; if (b_v_mem !== -12'sd2048) begin n_err++; $display("FAIL t3_step16: got %0d want -2048", b_v_mem); end
         end
         if (i == 17) begin
            n_cmp++; if (b_v_mem !== -12'sd2048 || b_busy !== 1'b1) begin
               n_err++; $display("FAIL t3_step17: got v=%0d busy=%b want v=-2048 busy=1", b_v_mem, b_busy);
            end
         end
      end
      n_cmp++; if (any_spike !== 1'b0 || b_spike_count !== 8'd0) begin
         n_err++; $display("FAIL t3_nospike: got spk=%b cnt=%0d want 0 0", any_spike, b_spike_count);
      end
   endtask

   task automatic test_start_priority();
      pulse_start();
      drive_step(8'h40);
      n_cmp++; if (v_mem !== 12'sd64) begin n_err++; $display("FAIL t4_step1: got %0d want 64", v_mem); end
      drive_step(8'h40);
      n_cmp++; if (v_mem !== 12'sd120) begin n_err++; $display("FAIL t4_step2: got %0d want 120", v_mem); end
      start = 1'b1; sum = 8'h40; sum_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; sum_valid = 1'b0;
      n_cmp++; if (v_mem !== 12'sd0 || step_valid !== 1'b0 || busy !== 1'b1 || spike_count !== 8'd0) begin
         n_err++; $display("FAIL t4_restart: got v=%0d sv=%b busy=%b cnt=%0d want v=0 sv=0 busy=1 cnt=0",
                           v_mem, step_valid, busy, spike_count);
      end
      // A fresh step counter means done arrives on exactly the 16th following step.
      for (int i = 0; i < 16; i++) begin
         drive_step(8'h00);
         n_cmp++; if (done !== (i == 15) || v_mem !== 12'sd0) begin
            n_err++; $display("FAIL t4_count%0d: got done=%b v=%0d want done=%0d v=0", i + 1, done, v_mem, (i == 15));
         end
      end
   endtask

   task automatic test_reset_refract();
      pulse_start();
      drive_step(8'h7F);
      drive_step(8'h7F);
      drive_step(8'h7F);
      drive_step(8'h7F);
      n_cmp++; if (v_mem !== 12'sd0 || step_valid !== 1'b1 || spike !== 1'b0 || busy !== 1'b1 || spike_count !== 8'd1) begin
         n_err++; $display("FAIL t5_refract: got v=%0d sv=%b spk=%b busy=%b cnt=%0d want v=0 sv=1 spk=0 busy=1 cnt=1",
                           v_mem, step_valid, spike, busy, spike_count);
      end
      rst_n = 1'b0; sum = 8'h7F; sum_valid = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1; sum_valid = 1'b0;
      n_cmp++; if (v_mem !== 12'sd0 || busy !== 1'b0 || spike_count !== 8'd0 || {spike, step_valid, done} !== 3'b000) begin
         n_err++; $display("FAIL t5_reset: got v=%0d busy=%b cnt=%0d pulses=%b want v=0 busy=0 cnt=0 pulses=000",
                           v_mem, busy, spike_count, {spike, step_valid, done});
      end
      drive_step(8'h7F);
      n_cmp++; if (step_valid !== 1'b0 || v_mem !== 12'sd0 || busy !== 1'b0) begin
         n_err++; $display("FAIL t5_idle_ignore: got sv=%b v=%0d busy=%b want sv=0 v=0 busy=0", step_valid, v_mem, busy);
      end
   endtask

   task automatic test_gapped();
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         drive_step(8'h7F);
         n_cmp++;
         if (v_mem !== 12'(exp_v[i]) || spike !== exp_spk[i][0] || spike_count !== 8'(exp_cnt[i]) || done !== (i == 15)) begin
            n_err++;
            $display("FAIL t6_step%0d: got v=%0d spk=%b cnt=%0d done=%b want v=%0d spk=%0d cnt=%0d done=%0d",
                     i + 1, v_mem, spike, spike_count, done, exp_v[i], exp_spk[i], exp_cnt[i], (i == 15));
         end
         repeat (2) @(posedge clk);
         #1;
         n_cmp++; if (step_valid !== 1'b0 || v_mem !== 12'(exp_v[i])) begin
            n_err++; $display("FAIL t6_gap%0d: got sv=%b v=%0d want sv=0 v=%0d", i + 1, step_valid, v_mem, exp_v[i]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; sum_valid = 1'b0; sum = 8'h00;
      b_start = 1'b0; b_sum_valid = 1'b0; b_sum = 8'h00;
      test_reset();
      test_first_spike();
      test_full_window();
      test_saturation();
      test_start_priority();
      test_reset_refract();
      test_gapped();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
